// File: rtl/axis_frame_serializer_if.sv
// Send-side and Aurora AXI4-Stream TX signals of axis_frame_serializer, bundled
// so the serializer and its driver share one port. slave is the serializer's view.
interface axis_frame_serializer_if #(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int SEND_DATA_WIDTH   = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int TTL_WIDTH         = 2,
  parameter int ROUTER_ID_WIDTH   = 2
);
  logic                         send_valid;
  logic                         send_ready;
  logic [SEND_DATA_WIDTH-1:0]   send_data;
  logic [ADDR_WIDTH-1:0]        dst_addr;
  logic [TTL_WIDTH-1:0]         ttl;
  logic [ROUTER_ID_WIDTH-1:0]   router_id;
  logic                         axis_tx_tvalid;
  logic                         axis_tx_tready;
  logic [AURORA_DATA_WIDTH-1:0] axis_tx_tdata;
  logic                         axis_tx_tlast;
  logic                         done_serializer;
  logic                         busy;

  modport master (
    output send_valid, send_data, dst_addr, ttl, router_id, axis_tx_tready,
    input  send_ready, axis_tx_tvalid, axis_tx_tdata, axis_tx_tlast,
           done_serializer, busy
  );

  modport slave (
    input  send_valid, send_data, dst_addr, ttl, router_id, axis_tx_tready,
    output send_ready, axis_tx_tvalid, axis_tx_tdata, axis_tx_tlast,
           done_serializer, busy
  );
endinterface

// File: rtl/axis_frame_serializer.sv
// Serializes one wide send word into an Aurora AXIS frame: header beat plus payload beats,
// with tready backpressure. Define SERIALIZER_CHECKSUM_EN to append an XOR checksum beat.
module axis_frame_serializer #(
  parameter int NUM_LANE          = 1,
  parameter int AURORA_DATA_WIDTH = 64 * NUM_LANE,
  parameter int SEND_DATA_WIDTH   = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int TTL_WIDTH         = 2,
  parameter int ROUTER_ID_WIDTH   = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  axis_frame_serializer_if.slave   bus
);
  localparam int DW        = AURORA_DATA_WIDTH;
  localparam int SW        = SEND_DATA_WIDTH;
  localparam int RW        = ROUTER_ID_WIDTH;
  localparam int P         = DW - 1 - RW;
  localparam int NUM_BEATS = (SW + P - 1) / P;
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);
  localparam int PAD_W     = NUM_BEATS * P;
  localparam int HDR_W     = ADDR_WIDTH + TTL_WIDTH + RW + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  if (HDR_W > DW) begin : g_bad_width
    $error("axis_frame_serializer: header fields (%0d bits) exceed AXIS width %0d", HDR_W, DW);
  end

`ifdef SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_CHECKSUM} state_e;
  logic [P-1:0] csum_q, csum_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_e;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PAD_W-1:0]      data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TTL_WIDTH-1:0]  ttl_q, ttl_d;
  logic [RW-1:0]         rid_q, rid_d;
  logic                  done_q, done_d;

  logic          tvalid;
  logic          tlast;
  logic [DW-1:0] tdata;
  logic [P-1:0]  chunk;

  // The capture register shifts down one chunk per accepted payload beat.
  assign chunk = data_q[P-1:0];

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    ttl_d   = ttl_q;
    rid_d   = rid_q;
    done_d  = 1'b0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tdata   = '0;
`ifdef SERIALIZER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef SERIALIZER_CHECKSUM_EN
        csum_d = '0;
`endif
        if (bus.send_valid) begin
          data_d  = PAD_W'(bus.send_data);
          addr_d  = bus.dst_addr;
          ttl_d   = bus.ttl;
          rid_d   = bus.router_id;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        tvalid             = 1'b1;
        tdata[HDR_W-1:0]   = {addr_q, ttl_q, rid_q, 1'b1};
        if (bus.axis_tx_tready) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        tvalid = 1'b1;
        tdata  = {chunk, rid_q, 1'b0};
`ifndef SERIALIZER_CHECKSUM_EN
        tlast  = (cnt_q == LAST_CNT);
`endif
        if (bus.axis_tx_tready) begin
          data_d = data_q >> P;
`ifdef SERIALIZER_CHECKSUM_EN
          csum_d = csum_q ^ chunk;
`endif
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef SERIALIZER_CHECKSUM_EN
            state_d = S_CHECKSUM;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      S_CHECKSUM: begin
        tvalid = 1'b1;
        tlast  = 1'b1;
        tdata  = {csum_q, rid_q, 1'b0};
        if (bus.axis_tx_tready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  // NOTE: the capture registers are reset as well, so no stale fields survive an aborted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      ttl_q   <= '0;
      rid_q   <= '0;
      done_q  <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      ttl_q   <= ttl_d;
      rid_q   <= rid_d;
      done_q  <= done_d;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.send_ready      = (state_q == S_IDLE);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done_serializer = done_q;
  assign bus.axis_tx_tvalid  = tvalid;
  assign bus.axis_tx_tlast   = tlast;
  assign bus.axis_tx_tdata   = tdata;

endmodule

// File: tb/tb_axis_frame_serializer.sv
// Scoreboard bench for axis_frame_serializer: accepted sends push their expected beats,
// a negedge monitor pops and compares every accepted beat and the control outputs.
module tb_axis_frame_serializer;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int NUM_LANE = 2;
  localparam int CSUM     = 1;
`else
  localparam int NUM_LANE = 1;
  localparam int CSUM     = 0;
`endif
  localparam int DW = 64 * NUM_LANE;
  localparam int SW = 1024;
  localparam int AW = 10;
  localparam int TW = 2;
  localparam int RW = 2;
  localparam int P  = DW - 1 - RW;
  localparam int NB = (SW + P - 1) / P;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_frame_serializer_if #(
    .AURORA_DATA_WIDTH(DW), .SEND_DATA_WIDTH(SW), .ADDR_WIDTH(AW),
    .TTL_WIDTH(TW), .ROUTER_ID_WIDTH(RW)
  ) bus ();

  axis_frame_serializer #(
    .NUM_LANE(NUM_LANE), .AURORA_DATA_WIDTH(DW), .SEND_DATA_WIDTH(SW),
    .ADDR_WIDTH(AW), .TTL_WIDTH(TW), .ROUTER_ID_WIDTH(RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  bit    in_frame       = 0;
  bit    expect_done    = 0;
  int    beats_in_frame = 0;
  int    tready_mode    = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference frame: header, chunks cut from the send word bit by bit, optional XOR beat.
  task automatic push_frame(input logic [SW-1:0] sd, input logic [AW-1:0] dst,
                            input logic [TW-1:0] t, input logic [RW-1:0] rid);
    beat_t         b;
    logic [P-1:0]  chunk;
    logic [P-1:0]  x;
    logic [DW-1:0] hdr;
    hdr = (DW'(dst) << (TW + RW + 1)) | (DW'(t) << (RW + 1)) | (DW'(rid) << 1) | DW'(1);
    b.data = hdr;
    b.last = 1'b0;
    exp_q.push_back(b);
    x = '0;
    for (int k = 0; k < NB; k++) begin
      chunk = '0;
      for (int i = 0; i < P; i++)
        if (k * P + i < SW) chunk[i] = sd[k * P + i];
      x ^= chunk;
      b.data = {chunk, rid, 1'b0};
      b.last = (CSUM == 0) && (k == NB - 1);
      exp_q.push_back(b);
    end
    if (CSUM != 0) begin
      b.data = {x, rid, 1'b0};
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Monitor: samples on the falling edge, predicts what the next rising edge commits.
  initial begin : monitor
    beat_t         b;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        check("rst tvalid", DW'(bus.axis_tx_tvalid), '0);
        check("rst tdata", bus.axis_tx_tdata, '0);
        check("rst tlast", DW'(bus.axis_tx_tlast), '0);
        check("rst done", DW'(bus.done_serializer), '0);
        check("rst busy", DW'(bus.busy), '0);
        check("rst send_ready", DW'(bus.send_ready), DW'(1));
        exp_q.delete();
        in_frame       = 0;
        expect_done    = 0;
        beats_in_frame = 0;
        prev_stall     = 0;
        continue;
      end
      check("busy", DW'(bus.busy), DW'(in_frame));
      check("send_ready", DW'(bus.send_ready), DW'(!in_frame));
      check("tvalid", DW'(bus.axis_tx_tvalid), DW'(in_frame));
      check("done", DW'(bus.done_serializer), DW'(expect_done));
      if (!in_frame) begin
        check("idle tdata", bus.axis_tx_tdata, '0);
        check("idle tlast", DW'(bus.axis_tx_tlast), '0);
      end
      if (prev_stall) begin
        check("stall tdata", bus.axis_tx_tdata, prev_data);
        check("stall tlast", DW'(bus.axis_tx_tlast), DW'(prev_last));
      end
      expect_done = 0;
      prev_stall  = bus.axis_tx_tvalid && !bus.axis_tx_tready;
      prev_data   = bus.axis_tx_tdata;
      prev_last   = bus.axis_tx_tlast;
      if (bus.send_valid && bus.send_ready) begin
        push_frame(bus.send_data, bus.dst_addr, bus.ttl, bus.router_id);
        in_frame       = 1;
        beats_in_frame = 0;
      end
      if (bus.axis_tx_tvalid && bus.axis_tx_tready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected beat");
        end else begin
          b = exp_q.pop_front();
          check($sformatf("beat %0d tdata", beats_in_frame), bus.axis_tx_tdata, b.data);
          check($sformatf("beat %0d tlast", beats_in_frame), DW'(bus.axis_tx_tlast), DW'(b.last));
          beats_in_frame++;
          if (b.last) begin
            in_frame    = 0;
            expect_done = 1;
          end
        end
      end
    end
  end

  // tready: constant 1, the 1,0,0,1 pattern, or random.
  initial begin : tready_drv
    int phase = 0;
    bus.axis_tx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        1:       bus.axis_tx_tready = (phase % 4 == 0) || (phase % 4 == 3);
        2:       bus.axis_tx_tready = 1'($urandom_range(0, 1));
        default: bus.axis_tx_tready = 1'b1;
      endcase
      phase++;
    end
  end

  function automatic logic [SW-1:0] rand_word();
    logic [SW-1:0] w;
    for (int i = 0; i < SW / 32; i++) w[i * 32 +: 32] = $urandom;
    return w;
  endfunction

  // Holds send_valid until accepted, then scrambles the inputs to prove capture isolation.
  task automatic send(input logic [SW-1:0] sd, input logic [AW-1:0] dst,
                      input logic [TW-1:0] t, input logic [RW-1:0] rid);
    int n = 0;
    bus.send_valid = 1'b1;
    bus.send_data  = sd;
    bus.dst_addr   = dst;
    bus.ttl        = t;
    bus.router_id  = rid;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.send_ready && n < 500);
    if (!bus.send_ready) fail_now("send accept timeout");
    @(posedge clk);
    #1;
    bus.send_valid = 1'b0;
    bus.send_data  = rand_word();
    bus.dst_addr   = AW'($urandom);
    bus.ttl        = TW'($urandom);
    bus.router_id  = RW'($urandom);
  endtask

  task automatic send_rand();
    send(rand_word(), AW'($urandom), TW'($urandom), RW'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || expect_done) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("frame drain timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [SW-1:0] pat;
    int n;
    rst_n          = 1'b0;
    bus.send_valid = 1'b0;
    bus.send_data  = '0;
    bus.dst_addr   = '0;
    bus.ttl        = '0;
    bus.router_id  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed frame: incrementing byte pattern, dst 0x2A5, ttl 2, router 1.
    for (int i = 0; i < SW / 8; i++) pat[i * 8 +: 8] = 8'(i);
    tready_mode = 0;
    send(pat, 10'h2A5, 2'd2, 2'd1);
    wait_idle();

    // Stalls with the 1,0,0,1 tready pattern.
    tready_mode = 1;
    send_rand();
    wait_idle();

    // send_valid held across two frames.
    tready_mode = 0;
    send_rand();
    send_rand();
    wait_idle();

    // Reset while payload beat 8 is on the bus, then a clean frame.
    send_rand();
    n = 0;
    while (beats_in_frame < 9 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) fail_now("reset point timeout");
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst tvalid", DW'(bus.axis_tx_tvalid), '0);
    check("async rst send_ready", DW'(bus.send_ready), DW'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_rand();
    wait_idle();

    // Random backpressure, random gaps, some back-to-back.
    tready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_frame_serializer.md
Name: axis_frame_serializer

Overview:
Parametrised successor to the router TX serializer. It accepts one wide send word plus routing fields and emits an Aurora AXI4-Stream frame: one header beat followed by N payload beats. Unlike the previous generation it honours tready backpressure, has a send-side valid/ready handshake, supports any lane count and send width, and zero-pads the final partial beat. It sits between the router send buffer and the Aurora TX user interface.

Parameters:
NUM_LANE, 1, Aurora lane count.
AURORA_DATA_WIDTH, 64*NUM_LANE, AXIS tdata width (DW).
SEND_DATA_WIDTH, 1024, width of one send word (SW).
ADDR_WIDTH, 10, destination address width.
TTL_WIDTH, 2, TTL field width.
ROUTER_ID_WIDTH, 2, router id field width (RW).
PAYLOAD_WIDTH, DW-1-RW, payload bits per beat (P), derived.
NUM_BEATS, ceil(SW/P), payload beats per frame, derived; default 17.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
send_valid  in  1  send word and fields valid
send_ready  out  1  block can accept a send word
send_data  in  SW  data word
dst_addr  in  ADDR_WIDTH  destination address
ttl  in  TTL_WIDTH  time-to-live
router_id  in  RW  source router id
axis_tx_tvalid  out  1  stream beat valid
axis_tx_tready  in  1  Aurora accepts beat
axis_tx_tdata  out  DW  stream beat data
axis_tx_tlast  out  1  last beat of frame
done_serializer  out  1  one-cycle pulse, frame fully accepted
busy  out  1  frame in progress

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk. Reset: state IDLE, all outputs 0 except send_ready=1, beat counter 0, capture registers 0. Reset mid-frame aborts the frame; no done pulse.
- Elaboration check: ADDR_WIDTH+TTL_WIDTH+RW+1 <= DW, otherwise $error.
- States: IDLE -> HEADER -> PAYLOAD -> (CHECKSUM, optional) -> IDLE.
- IDLE: send_ready=1, busy=0. On send_valid&&send_ready at cycle T, capture send_data, dst_addr, ttl and router_id. Go to HEADER; the header beat is presented at T+1.
- Header beat: tdata = {zeros, dst_addr, ttl, router_id, 1'b1}; tlast=0.
- Payload beat k (k=0..NUM_BEATS-1): tdata = {chunk_k, router_id, 1'b0}, where chunk_k = send_data[k*P +: P]. Bits at or above SW are 0 (zero-pad the final beat). Beat k=0 carries the LSBs.
- A beat advances only on tvalid&&tready. While tvalid&&!tready, tdata, tlast and tvalid are held stable. tvalid never drops mid-frame.
- tlast=1 only on the final beat: payload beat NUM_BEATS-1, or the checksum beat when enabled.
- Final beat accepted at cycle L: at L+1, tvalid=0, tlast=0, tdata=0, done_serializer=1 for exactly one cycle, state=IDLE, send_ready=1. A new send may be accepted in that same cycle L+1.
- Fully pipelined with tready=1 constantly: a frame occupies NUM_BEATS+1 (+1 with checksum) consecutive cycles.
- send_ready=0 outside IDLE. send_valid is ignored then; captured data is immune to input changes.
- The beat counter uses $clog2(NUM_BEATS+1) bits and clears on return to IDLE.
- busy = (state != IDLE).

Optional Feature:
Macro SERIALIZER_CHECKSUM_EN.
- Defined: after the last payload beat, emit one extra CHECKSUM beat. tdata = {xor of all P-bit chunk_k, router_id, 1'b0}, tlast=1; the last payload beat has tlast=0. The XOR accumulates on each accepted payload beat and clears in IDLE.
- Undefined: no CHECKSUM state or accumulator; the last payload beat carries tlast.

Test Plan:
- Defaults, tready=1, send dst_addr=0x2A5, ttl=2, router_id=1 -> header tdata=64'h54B3 at T+1. 17 payload beats follow with bit0=0 and bits[2:1]=01. tlast only on beat 17. done pulses at L+1.
- send_data = 1024-bit incrementing byte pattern -> beat k bits[63:3] = send_data[61k +: 61]. Beat 17 bits[63:51]=0 and bits[50:3]=send_data[1023:976].
- tready toggling 1,0,0,1 throughout the frame -> tdata/tlast stable during stalls. No beat is lost or duplicated; total accepted beats = 18.
- send_valid held high across two frames -> second header appears at L+2. send_ready=0 during frame 1. Frame 2 data matches the second capture.
- rst_n asserted during payload beat 8 -> all outputs 0 and send_ready=1 immediately. No done pulse. The next send produces a clean complete frame.
- NUM_LANE=2 with SERIALIZER_CHECKSUM_EN defined -> P=125, 9 payload beats plus a checksum beat. Checksum equals the XOR of the chunks; tlast only on the checksum beat.
